video_timing_gen: RTL

- Generates raster timing for the HDMI output path: counts horizontal and vertical pixel positions and produces vs/hs/de.
- Also produces active-area coordinates act_x/act_y and a frame-start strobe.
- Sits directly upstream of the pattern generator and the frame-buffer read stage; those consume vs/hs/de/act_x on the same pix_clk cycle.
- Timing is fully parameterised; defaults are 1280x720@60 (74.25 MHz pixel clock).

---
 rtl/video_timing_gen.sv | 111 +++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: walks (h_cnt, v_cnt) over the full frame and emits
// registered hs/vs/de, active-area coordinates and a frame-start strobe.
module video_timing_gen #(
  parameter int unsigned X_BITS = 13,
  parameter int unsigned Y_BITS = 13,
  parameter int unsigned H_SYNC = 40,
  parameter int unsigned H_BP   = 220,
  parameter int unsigned H_ACT  = 1280,
  parameter int unsigned H_FP   = 110,
  parameter int unsigned V_SYNC = 5,
  parameter int unsigned V_BP   = 20,
  parameter int unsigned V_ACT  = 720,
  parameter int unsigned V_FP   = 5,
  parameter bit          HS_POL = 1'b1,
  parameter bit          VS_POL = 1'b1
) (
  input  logic              pix_clk,
  input  logic              rstn,
  input  logic              en,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [X_BITS-1:0] act_x,
  output logic [Y_BITS-1:0] act_y,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned V_START = V_SYNC + V_BP;

  localparam logic [X_BITS-1:0] H_LAST    = X_BITS'(H_TOTAL - 1);
  localparam logic [X_BITS-1:0] H_SYNC_X  = X_BITS'(H_SYNC);
  localparam logic [X_BITS-1:0] H_START_X = X_BITS'(H_START);
  localparam logic [X_BITS-1:0] H_END_X   = X_BITS'(H_START + H_ACT);
  localparam logic [Y_BITS-1:0] V_LAST    = Y_BITS'(V_TOTAL - 1);
  localparam logic [Y_BITS-1:0] V_SYNC_Y  = Y_BITS'(V_SYNC);
  localparam logic [Y_BITS-1:0] V_START_Y = Y_BITS'(V_START);
  localparam logic [Y_BITS-1:0] V_END_Y   = Y_BITS'(V_START + V_ACT);

  // Counters must be able to hold the full blanking-inclusive frame.
  if (64'(H_TOTAL) >= (64'd1 << X_BITS)) begin : g_h_range_bad
    $fatal(1, "video_timing_gen: H_TOTAL does not fit in X_BITS");
  end
  if (64'(V_TOTAL) >= (64'd1 << Y_BITS)) begin : g_v_range_bad
    $fatal(1, "video_timing_gen: V_TOTAL does not fit in Y_BITS");
  end

  logic [X_BITS-1:0] h_cnt;
  logic [Y_BITS-1:0] v_cnt;

  logic              hs_nxt;
  logic              vs_nxt;
  logic              de_nxt;
  logic              fs_nxt;
  logic [X_BITS-1:0] ax_nxt;
  logic [Y_BITS-1:0] ay_nxt;

  always_comb begin
    hs_nxt = (h_cnt < H_SYNC_X) ? HS_POL : ~HS_POL;
    vs_nxt = (v_cnt < V_SYNC_Y) ? VS_POL : ~VS_POL;
    de_nxt = (h_cnt >= H_START_X) && (h_cnt < H_END_X) &&
             (v_cnt >= V_START_Y) && (v_cnt < V_END_Y);
    fs_nxt = (h_cnt == '0) && (v_cnt == '0);
    ax_nxt = '0;
    ay_nxt = '0;
    if (de_nxt) begin
      ax_nxt = h_cnt - H_START_X;
      ay_nxt = v_cnt - V_START_Y;
    end
  end

  // Outputs describe the position held before the edge; counters advance on
  // the same edge, so downstream sees (0,0) on the first enabled cycle.
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hs_out      <= ~HS_POL;
      vs_out      <= ~VS_POL;
      de_out      <= 1'b0;
      act_x       <= '0;
      act_y       <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hs_out      <= ~HS_POL;
      vs_out      <= ~VS_POL;
      de_out      <= 1'b0;
      act_x       <= '0;
      act_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      hs_out      <= hs_nxt;
      vs_out      <= vs_nxt;
      de_out      <= de_nxt;
      act_x       <= ax_nxt;
      act_y       <= ay_nxt;
      frame_start <= fs_nxt;
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

endmodule
